// File: rtl/ddr_cmd_scheduler.sv
// ddr_cmd_scheduler
// Command scheduler that sits in front of a DDR command state machine. It runs
// the initialization sequence, then serves single host accesses with a
// closed-page policy (ACT, READ/WRITE, PRE for every access). A free-running
// interval timer schedules periodic refreshes, and refreshes take priority
// over new accesses.
//
// Cycle timing: a command pulse shown "in cycle n" is registered on edge n-1.
// Edge 0 is the first rising edge that samples RESET low.
//
// Handshake: req_valid/req_ready follow strict valid/ready semantics. A request
// is taken on a rising edge where both are high, and req_write is captured on
// that edge. req_valid and req_write are ignored on every other edge, and the
// host must keep the request up until it is taken. req_ready does not depend
// on req_valid.
//
// Ports
//   CLK, RESET            clock; synchronous active-high reset
//   req_valid, req_write  host request and direction (1 = write)
//   req_ready             request can be taken this cycle
//   ZQCL, MRS, ACT, READ, WRITE, PRE, REF
//                         registered one-cycle command pulses
//   init_done             initialization complete (level)
//   busy                  state is not IDLE
//   ref_overflow          sticky: the interval wrapped while a refresh was
//                         still pending
//   state_dbg             current FSM state encoding
//
// The timing parameters TMRD, TRCD, TRP and TRFC are effective with a minimum
// of 2, because each command spends one cycle in its own command state.
module ddr_cmd_scheduler #(
  parameter int TZQ   = 8,
  parameter int TMRD  = 4,
  parameter int TRCD  = 3,
  parameter int TRP   = 3,
  parameter int TRFC  = 8,
  parameter int TREFI = 100
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req_valid,
  input  logic       req_write,
  output logic       req_ready,
  output logic       ZQCL,
  output logic       MRS,
  output logic       ACT,
  output logic       READ,
  output logic       WRITE,
  output logic       PRE,
  output logic       REF,
  output logic       init_done,
  output logic       busy,
  output logic       ref_overflow,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    INIT_ZQ   = 4'd0,
    ZQ_WAIT   = 4'd1,
    INIT_MRS  = 4'd2,
    MRD_WAIT  = 4'd3,
    IDLE      = 4'd4,
    ACTIVATE  = 4'd5,
    RCD_WAIT  = 4'd6,
    RDWR      = 4'd7,
    RTP_WAIT  = 4'd8,
    PRECHARGE = 4'd9,
    RP_WAIT   = 4'd10,
    REFRESH   = 4'd11,
    RFC_WAIT  = 4'd12
  } state_t;

  localparam int CW = 16;
  localparam int TW = (TREFI > 1) ? $clog2(TREFI) : 1;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [TW-1:0] refi_cnt;
  logic          ref_pending;
  logic          wr_latched;
  logic          refi_wrap;
  logic          issue_ref;
  logic          accept;

  assign refi_wrap = init_done && (refi_cnt == TW'(TREFI - 1));
  assign issue_ref = (state == IDLE) && init_done && ref_pending;
  assign req_ready = (state == IDLE) && init_done && !ref_pending;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= INIT_ZQ;
      wait_cnt     <= '0;
      refi_cnt     <= '0;
      ref_pending  <= 1'b0;
      ref_overflow <= 1'b0;
      init_done    <= 1'b0;
      wr_latched   <= 1'b0;
      ZQCL         <= 1'b0;
      MRS          <= 1'b0;
      ACT          <= 1'b0;
      READ         <= 1'b0;
      WRITE        <= 1'b0;
      PRE          <= 1'b0;
      REF          <= 1'b0;
    end else begin
      // Pulses are high for one cycle only.
      ZQCL  <= 1'b0;
      MRS   <= 1'b0;
      ACT   <= 1'b0;
      READ  <= 1'b0;
      WRITE <= 1'b0;
      PRE   <= 1'b0;
      REF   <= 1'b0;

      // The refresh interval timer keeps running through accesses and
      // refreshes, so the refresh cadence does not drift with traffic.
      if (init_done) begin
        if (refi_wrap) refi_cnt <= '0;
        else           refi_cnt <= refi_cnt + 1'b1;
      end

      // A wrap on the same edge as a REF opens the next interval, so the
      // set must take priority over the clear.
      if (refi_wrap)      ref_pending <= 1'b1;
      else if (issue_ref) ref_pending <= 1'b0;

      if (refi_wrap && ref_pending && !issue_ref) ref_overflow <= 1'b1;

      // wait_cnt is loaded with (gap - 1) when a command issues. The command
      // state and the wait state both count it down, and the next event
      // fires on the edge where the wait state sees zero.
      case (state)
        INIT_ZQ: begin
          ZQCL     <= 1'b1;
          wait_cnt <= CW'(TZQ - 1);
          state    <= ZQ_WAIT;
        end
        ZQ_WAIT: begin
          if (wait_cnt == '0) begin
            MRS      <= 1'b1;
            wait_cnt <= CW'(TMRD - 1);
            state    <= INIT_MRS;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        INIT_MRS: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
          state <= MRD_WAIT;
        end
        MRD_WAIT: begin
          if (wait_cnt == '0) begin
            init_done <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        IDLE: begin
          // A pending refresh blocks req_ready, so it always wins over a
          // request that is waiting.
          if (issue_ref) begin
            REF      <= 1'b1;
            wait_cnt <= CW'(TRFC - 1);
            state    <= REFRESH;
          end else if (accept) begin
            ACT        <= 1'b1;
            wr_latched <= req_write;
            wait_cnt   <= CW'(TRCD - 1);
            state      <= ACTIVATE;
          end
        end
        ACTIVATE: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
          state <= RCD_WAIT;
        end
        RCD_WAIT: begin
          if (wait_cnt == '0) begin
            READ     <= !wr_latched;
            WRITE    <= wr_latched;
            wait_cnt <= CW'(1);   // PRE follows the column command by 2 cycles
            state    <= RDWR;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RDWR: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
          state <= RTP_WAIT;
        end
        RTP_WAIT: begin
          if (wait_cnt == '0) begin
            PRE      <= 1'b1;
            wait_cnt <= CW'(TRP - 1);
            state    <= PRECHARGE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        PRECHARGE: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
          state <= RP_WAIT;
        end
        RP_WAIT: begin
          if (wait_cnt == '0) state <= IDLE;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        REFRESH: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
          state <= RFC_WAIT;
        end
        RFC_WAIT: begin
          if (wait_cnt == '0) state <= IDLE;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        default: state <= INIT_ZQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Testbench for ddr_cmd_scheduler.
// dut0: default parameters. It is driven by a per-cycle vector table and then
//       by a hand-written sequence that resets it in the middle of an access.
// dut1: TREFI=10 with a continuous request stream (no overflow expected).
// dut2: TREFI=10, TRCD=6 with a continuous request stream (overflow expected).
// Cycle n means the outputs seen after edge n-1. Edge 0 is the first edge
// that samples reset low.
module tb_ddr_cmd_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] C_ZQ  = 7'b1000000;
  localparam logic [6:0] C_MRS = 7'b0100000;
  localparam logic [6:0] C_ACT = 7'b0010000;
  localparam logic [6:0] C_RD  = 7'b0001000;
  localparam logic [6:0] C_WR  = 7'b0000100;
  localparam logic [6:0] C_PRE = 7'b0000010;
  localparam logic [6:0] C_REF = 7'b0000001;

  logic rst0 = 1'b1, valid0 = 1'b0, write0 = 1'b0;
  logic rst1 = 1'b1, valid1 = 1'b0, write1 = 1'b0;
  logic rst2 = 1'b1, valid2 = 1'b0, write2 = 1'b0;
  wire  ready0, init0, busy0, ovf0;
  wire  ready1, init1, busy1, ovf1;
  wire  ready2, init2, busy2, ovf2;
  wire [6:0] cmd0, cmd1, cmd2;
  wire [3:0] st0, st1, st2;

  ddr_cmd_scheduler dut0 (
    .CLK(clk), .RESET(rst0), .req_valid(valid0), .req_write(write0),
    .req_ready(ready0), .ZQCL(cmd0[6]), .MRS(cmd0[5]), .ACT(cmd0[4]),
    .READ(cmd0[3]), .WRITE(cmd0[2]), .PRE(cmd0[1]), .REF(cmd0[0]),
    .init_done(init0), .busy(busy0), .ref_overflow(ovf0), .state_dbg(st0)
  );

  ddr_cmd_scheduler #(.TREFI(10)) dut1 (
    .CLK(clk), .RESET(rst1), .req_valid(valid1), .req_write(write1),
    .req_ready(ready1), .ZQCL(cmd1[6]), .MRS(cmd1[5]), .ACT(cmd1[4]),
    .READ(cmd1[3]), .WRITE(cmd1[2]), .PRE(cmd1[1]), .REF(cmd1[0]),
    .init_done(init1), .busy(busy1), .ref_overflow(ovf1), .state_dbg(st1)
  );

  ddr_cmd_scheduler #(.TREFI(10), .TRCD(6)) dut2 (
    .CLK(clk), .RESET(rst2), .req_valid(valid2), .req_write(write2),
    .req_ready(ready2), .ZQCL(cmd2[6]), .MRS(cmd2[5]), .ACT(cmd2[4]),
    .READ(cmd2[3]), .WRITE(cmd2[2]), .PRE(cmd2[1]), .REF(cmd2[0]),
    .init_done(init2), .busy(busy2), .ref_overflow(ovf2), .state_dbg(st2)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int cyc,
                     input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- vector table ----------------
  // Each record gives the inputs applied from its cycle on, and the outputs
  // expected in that cycle. Cycles without a record expect no command pulse.
  typedef struct {
    int         cyc;
    logic       valid;
    logic       write;
    logic [6:0] cmd;
    logic       ready;
    logic       init;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int c, logic v, logic w, logic [6:0] cm,
                              logic r, logic i, logic b);
    vec_t t;
    t.cyc = c; t.valid = v; t.write = w; t.cmd = cm;
    t.ready = r; t.init = i; t.busy = b;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int   idx;
    int   ref_cnt;
    int   first_ref;
    int   first_act;
    int   first_ovf;
    logic hit;
    logic [6:0] exp_cmd;

    // cyc, valid, write, cmd, ready, init_done, busy
    tbl.push_back(mk(1,   0, 0, C_ZQ,  0, 0, 1));
    tbl.push_back(mk(2,   1, 0, 7'd0,  0, 0, 1)); // request during init: ignored
    tbl.push_back(mk(6,   0, 0, 7'd0,  0, 0, 1));
    tbl.push_back(mk(9,   0, 0, C_MRS, 0, 0, 1));
    tbl.push_back(mk(12,  0, 0, 7'd0,  0, 0, 1));
    tbl.push_back(mk(13,  1, 1, 7'd0,  1, 1, 0)); // write accepted k=13
    tbl.push_back(mk(14,  0, 0, C_ACT, 0, 1, 1));
    tbl.push_back(mk(17,  0, 0, C_WR,  0, 1, 1));
    tbl.push_back(mk(19,  0, 0, C_PRE, 0, 1, 1));
    tbl.push_back(mk(21,  0, 0, 7'd0,  0, 1, 1));
    tbl.push_back(mk(22,  0, 0, 7'd0,  1, 1, 0));
    tbl.push_back(mk(112, 0, 0, 7'd0,  1, 1, 0));
    tbl.push_back(mk(113, 1, 1, 7'd0,  0, 1, 0)); // ref_pending and req together
    tbl.push_back(mk(114, 1, 1, C_REF, 0, 1, 1));
    tbl.push_back(mk(121, 1, 1, 7'd0,  0, 1, 1));
    tbl.push_back(mk(122, 1, 0, 7'd0,  1, 1, 0)); // read accepted k=122
    tbl.push_back(mk(123, 0, 1, C_ACT, 0, 1, 1)); // write flips after acceptance
    tbl.push_back(mk(126, 0, 1, C_RD,  0, 1, 1));
    tbl.push_back(mk(128, 0, 1, C_PRE, 0, 1, 1));
    tbl.push_back(mk(130, 0, 1, 7'd0,  0, 1, 1));
    tbl.push_back(mk(131, 1, 1, 7'd0,  1, 1, 0)); // write accepted k=131
    tbl.push_back(mk(132, 1, 1, C_ACT, 0, 1, 1)); // valid held: no back-to-back
    tbl.push_back(mk(135, 1, 1, C_WR,  0, 1, 1));
    tbl.push_back(mk(137, 1, 1, C_PRE, 0, 1, 1));
    tbl.push_back(mk(140, 1, 0, 7'd0,  1, 1, 0)); // read accepted k=140
    tbl.push_back(mk(141, 0, 1, C_ACT, 0, 1, 1));
    tbl.push_back(mk(144, 0, 1, C_RD,  0, 1, 1));
    tbl.push_back(mk(146, 0, 1, C_PRE, 0, 1, 1));
    tbl.push_back(mk(149, 0, 1, 7'd0,  1, 1, 0));

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd",   0, 32'(cmd0),  0);
    chk("reset_ready", 0, 32'(ready0), 0);
    chk("reset_init",  0, 32'(init0),  0);
    chk("reset_busy",  0, 32'(busy0),  1);
    chk("reset_ovf",   0, 32'(ovf0),   0);
    rst0 = 1'b0;
    @(posedge clk); // edge 0
    #1;

    // ---- dut0 table-driven run ----
    idx = 0;
    for (int n = 1; n <= 149; n++) begin
      hit = (idx < tbl.size()) && (tbl[idx].cyc == n);
      if (hit) begin
        valid0 = tbl[idx].valid;
        write0 = tbl[idx].write;
      end
      @(negedge clk);
      exp_cmd = hit ? tbl[idx].cmd : 7'd0;
      chk("cmd", n, 32'(cmd0), 32'(exp_cmd));
      if (hit) begin
        chk("ready", n, 32'(ready0), 32'(tbl[idx].ready));
        chk("init",  n, 32'(init0),  32'(tbl[idx].init));
        chk("busy",  n, 32'(busy0),  32'(tbl[idx].busy));
        chk("ovf",   n, 32'(ovf0),   0);
        idx++;
      end
      @(posedge clk);
      #1;
    end

    // ---- dut0: reset during RCD_WAIT ----
    valid0 = 1'b1; write0 = 1'b1;               // cycle 150
    @(negedge clk);
    chk("mid_ready", 150, 32'(ready0), 1);
    @(posedge clk); #1;
    valid0 = 1'b0;                              // cycle 151
    @(negedge clk);
    chk("mid_act", 151, 32'(cmd0), 32'(C_ACT));
    @(posedge clk); #1;
    rst0 = 1'b1;                                // cycle 152, sampled at edge 152
    @(negedge clk);
    chk("mid_cmd152", 152, 32'(cmd0), 0);
    @(posedge clk); #1;
    @(negedge clk);                             // cycle 153
    chk("rst_cmd",   153, 32'(cmd0),   0);
    chk("rst_ready", 153, 32'(ready0), 0);
    chk("rst_init",  153, 32'(init0),  0);
    chk("rst_busy",  153, 32'(busy0),  1);
    chk("rst_ovf",   153, 32'(ovf0),   0);
    @(posedge clk); #1;
    @(negedge clk);                             // cycle 154
    chk("rst_cmd", 154, 32'(cmd0), 0);
    @(posedge clk); #1;
    rst0 = 1'b0;
    @(posedge clk); #1;                         // new edge 0
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      exp_cmd = (n == 1) ? C_ZQ : ((n == 9) ? C_MRS : 7'd0);
      chk("reinit_cmd",  n, 32'(cmd0),  32'(exp_cmd));
      chk("reinit_init", n, 32'(init0), (n >= 13) ? 1 : 0);
      @(posedge clk); #1;
    end

    // ---- dut1: TREFI=10, continuous requests, no overflow ----
    rst1 = 1'b0;
    valid1 = 1'b1;
    @(posedge clk); #1;                         // edge 0 for dut1
    ref_cnt = 0; first_ref = -1; first_act = -1;
    for (int n = 1; n <= 300; n++) begin
      write1 = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("s_ovf",    n, 32'(ovf1), 0);
      chk("s_onehot", n, ($countones(cmd1) <= 1) ? 1 : 0, 1);
      if (cmd1[0]) begin
        ref_cnt++;
        if (first_ref < 0) first_ref = n;
      end
      if (cmd1[4] && first_act < 0) first_act = n;
      @(posedge clk); #1;
    end
    valid1 = 1'b0;
    chk("s_first_act", 0, 32'(first_act), 14);
    chk("s_first_ref", 0, 32'(first_ref), 32);
    chk("s_ref_count_ge25", ref_cnt, (ref_cnt >= 25) ? 1 : 0, 1);

    // ---- dut2: TREFI shorter than an access, overflow is sticky ----
    rst2 = 1'b0;
    valid2 = 1'b1; write2 = 1'b0;
    @(posedge clk); #1;                         // edge 0 for dut2
    first_ovf = -1;
    for (int n = 1; n <= 120; n++) begin
      @(negedge clk);
      if (ovf2 === 1'b1 && first_ovf < 0) first_ovf = n;
      if (first_ovf > 0 && n > first_ovf) chk("o_sticky", n, 32'(ovf2), 1);
      chk("o_onehot", n, ($countones(cmd2) <= 1) ? 1 : 0, 1);
      @(posedge clk); #1;
    end
    chk("o_first_ovf", 0, 32'(first_ovf), 63);
    valid2 = 1'b0;
    rst2 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("o_ovf_after_reset",  0, 32'(ovf2),  0);
    chk("o_init_after_reset", 0, 32'(init2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
